// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Six-requester round-robin arbiter feeding a single registered write-back
//   port. A requester is granted and accepted in the same cycle (req_ready is
//   combinational); the winning result appears on wb_* one cycle later.
//   Results targeting register 0 are accepted but never written back.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   req_valid  per-requester result valid (bit i = requester i)
//   req_data   per-requester result, element i = requester i
//   req_rd     per-requester destination register index
//   req_ready  one-hot accept strobe to the granted requester (combinational)
//   wb_valid   registered write-back valid
//   wb_data    registered write-back data
//   wb_rd      registered write-back destination register
//   wb_sel     registered index of the requester that produced wb_data
//   wb_ready   downstream accepts wb_* this cycle
//   stall_cnt  saturating count of cycles with wb_valid=1 and wb_ready=0
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             req_valid,
  input  logic [5:0][DATA_W-1:0] req_data,
  input  logic [5:0][RD_W-1:0]   req_rd,
  output logic [5:0]             req_ready,
  output logic                   wb_valid,
  output logic [DATA_W-1:0]      wb_data,
  output logic [RD_W-1:0]        wb_rd,
  output logic [2:0]             wb_sel,
  input  logic                   wb_ready,
  output logic [15:0]            stall_cnt
);

  localparam int unsigned N_REQ = 6;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned POS_W = 4;
  localparam int unsigned CNT_W = 16;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_hit;
  logic [POS_W-1:0] pos;
  logic             load_en;
  logic             grant;
  logic             drop;
  logic             stall;

  // Output stage may load when empty or when its content is being consumed.
  assign load_en = !wb_valid || wb_ready;

  // Round-robin search: first valid requester starting at ptr, wrapping 5->0.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    pos      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      pos = POS_W'({1'b0, ptr}) + POS_W'(k);
      if (pos >= POS_W'(N_REQ)) begin
        pos = pos - POS_W'(N_REQ);
      end
      if (!scan_hit && req_valid[pos[SEL_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = pos[SEL_W-1:0];
      end
    end
  end

  // A grant needs a valid requester, a free output stage, and no reset.
  assign grant = rst_n && load_en && scan_hit;

  assign req_ready = grant ? 6'(6'b1 << scan_idx) : 6'b0;

  // Priority moves just past the winner.
  assign ptr_nxt = (scan_idx == SEL_W'(N_REQ - 1)) ? '0 : scan_idx + SEL_W'(1);

  // Writes to register 0 are swallowed at the arbiter.
  assign drop = (req_rd[scan_idx] == '0);

  assign stall = wb_valid && !wb_ready;

  // Pointer and write-back register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_sel   <= '0;
    end else if (load_en) begin
      if (grant) begin
        ptr <= ptr_nxt;
        if (drop) begin
          wb_valid <= 1'b0;
        end else begin
          wb_valid <= 1'b1;
          wb_data  <= req_data[scan_idx];
          wb_rd    <= req_rd[scan_idx];
          wb_sel   <= scan_idx;
        end
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Back-pressure counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
